// File: rtl/vend_pkg.sv
// ----------------------------------------------------------------------------
// vend_pkg
// Shared definitions for the vending controller:
//   - vend_state_e : controller state encoding (IDLE, COLLECT, VEND, CHANGE)
//   - COIN_*       : one-hot coin codes (bit3=50, bit2=20, bit1=10, bit0=5)
//   - VAL_*        : coin values in credit units
//   - coin_is_onehot / coin_value : decode helpers for a coin code
// ----------------------------------------------------------------------------
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } vend_state_e;

  localparam logic [3:0] COIN_50   = 4'b1000;
  localparam logic [3:0] COIN_20   = 4'b0100;
  localparam logic [3:0] COIN_10   = 4'b0010;
  localparam logic [3:0] COIN_5    = 4'b0001;
  localparam logic [3:0] COIN_NONE = 4'b0000;

  localparam logic [7:0] VAL_50 = 8'd50;
  localparam logic [7:0] VAL_20 = 8'd20;
  localparam logic [7:0] VAL_10 = 8'd10;
  localparam logic [7:0] VAL_5  = 8'd5;

  // True only for exactly one of the four legal coin codes.
  function automatic logic coin_is_onehot(input logic [3:0] code);
    logic ok;
    case (code)
      COIN_50, COIN_20, COIN_10, COIN_5: ok = 1'b1;
      default:                           ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Credit value of a coin code; illegal codes are worth nothing.
  function automatic logic [7:0] coin_value(input logic [3:0] code);
    logic [7:0] val;
    case (code)
      COIN_50: val = VAL_50;
      COIN_20: val = VAL_20;
      COIN_10: val = VAL_10;
      COIN_5:  val = VAL_5;
      default: val = 8'd0;
    endcase
    return val;
  endfunction

endpackage

// File: rtl/vend_change_sel.sv
// ----------------------------------------------------------------------------
// vend_change_sel
// Combinational greedy change picker: given the outstanding credit, selects
// the largest coin whose value does not exceed it.
// Ports:
//   credit_i [7:0] : credit still owed to the customer
//   coin_o   [3:0] : one-hot code of the chosen coin (0 when credit < 5)
//   value_o  [7:0] : value of the chosen coin (0 when no coin fits)
// ----------------------------------------------------------------------------
module vend_change_sel
  import vend_pkg::*;
(
  input  logic [7:0] credit_i,
  output logic [3:0] coin_o,
  output logic [7:0] value_o
);

  // Largest-first coin choice.
  always_comb begin
    coin_o  = COIN_NONE;
    value_o = 8'd0;
    if (credit_i >= VAL_50) begin
      coin_o  = COIN_50;
      value_o = VAL_50;
    end else if (credit_i >= VAL_20) begin
      coin_o  = COIN_20;
      value_o = VAL_20;
    end else if (credit_i >= VAL_10) begin
      coin_o  = COIN_10;
      value_o = VAL_10;
    end else if (credit_i >= VAL_5) begin
      coin_o  = COIN_5;
      value_o = VAL_5;
    end else begin
      coin_o  = COIN_NONE;
      value_o = 8'd0;
    end
  end

endmodule

// File: rtl/vend_ctrl.sv
// ----------------------------------------------------------------------------
// vend_ctrl
// Coin-operated vending controller. Collects coins into an 8-bit credit,
// vends one of four items on selection, and (optionally) pays out change
// one coin per cycle.
//
// Build option:
//   VEND_CHANGE_RETURN_EN defined   : leftover credit after a vend, or on
//                                     cancel, is returned through the CHANGE
//                                     state as greedy change coins.
//   VEND_CHANGE_RETURN_EN undefined : no CHANGE state; leftover credit stays
//                                     for the next purchase, cancel simply
//                                     clears credit; change_* outputs stay 0.
//
// Parameters: PRICE0..PRICE3 item prices (multiples of 5).
// Ports:
//   clk            : clock, rising edge
//   rst            : asynchronous active-low reset
//   coin_valid     : one-cycle pulse, coin_code carries an inserted coin
//   coin_code[3:0] : one-hot coin (bit3=50, bit2=20, bit1=10, bit0=5)
//   sel_valid      : one-cycle pulse, sel_item carries a selection
//   sel_item[1:0]  : selected item index
//   cancel         : one-cycle pulse, abort the purchase
//   credit[7:0]    : current credit
//   coin_reject    : pulse, the coin of the previous cycle was refused
//   sel_nack       : pulse, the previous selection was refused
//   dispense       : pulse, release item dispense_item
//   dispense_item  : item index, valid with dispense
//   change_valid   : pulse, release one change coin change_coin
//   change_coin    : one-hot coin, valid with change_valid
//   busy           : high while vending or paying change
// All outputs are registered.
// ----------------------------------------------------------------------------
module vend_ctrl
  import vend_pkg::*;
#(
  parameter logic [7:0] PRICE0 = 8'd15,
  parameter logic [7:0] PRICE1 = 8'd25,
  parameter logic [7:0] PRICE2 = 8'd35,
  parameter logic [7:0] PRICE3 = 8'd50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       coin_valid,
  input  logic [3:0] coin_code,
  input  logic       sel_valid,
  input  logic [1:0] sel_item,
  input  logic       cancel,
  output logic [7:0] credit,
  output logic       coin_reject,
  output logic       sel_nack,
  output logic       dispense,
  output logic [1:0] dispense_item,
  output logic       change_valid,
  output logic [3:0] change_coin,
  output logic       busy
);

  vend_state_e state_q;
  logic [7:0]  credit_q;
  logic [1:0]  vend_item_q;
  logic        coin_reject_q;
  logic        sel_nack_q;
  logic        dispense_q;
  logic [1:0]  dispense_item_q;
  logic        change_valid_q;
  logic [3:0]  change_coin_q;
  logic        busy_q;

  logic [7:0]  price_s;
  logic [7:0]  coin_val_s;
  logic [8:0]  coin_sum_s;
  logic        coin_fits_s;
  logic        cancel_act_s;
  logic [3:0]  chg_coin_s;
  logic [7:0]  chg_value_s;

  // Price lookup for the item being selected.
  always_comb begin
    case (sel_item)
      2'd0:    price_s = PRICE0;
      2'd1:    price_s = PRICE1;
      2'd2:    price_s = PRICE2;
      2'd3:    price_s = PRICE3;
      default: price_s = PRICE0;
    endcase
  end

  // Coin acceptance: legal code and no wrap past 255 (carry bit of the sum).
  assign coin_val_s  = coin_value(coin_code);
  assign coin_sum_s  = {1'b0, credit_q} + {1'b0, coin_val_s};
  assign coin_fits_s = coin_is_onehot(coin_code) && !coin_sum_s[8];

  // Cancel only has an effect while collecting with something to give back.
  assign cancel_act_s = cancel && (state_q == ST_COLLECT) && (credit_q != 8'd0);

  vend_change_sel u_change_sel (
    .credit_i (credit_q),
    .coin_o   (chg_coin_s),
    .value_o  (chg_value_s)
  );

`ifndef VEND_CHANGE_RETURN_EN
  // Change picker is idle in this build.
  logic unused_chg_s;
  assign unused_chg_s = ^{chg_coin_s, chg_value_s};
`endif

  // Controller FSM with registered pulse/data outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q         <= ST_IDLE;
      credit_q        <= 8'd0;
      vend_item_q     <= 2'd0;
      coin_reject_q   <= 1'b0;
      sel_nack_q      <= 1'b0;
      dispense_q      <= 1'b0;
      dispense_item_q <= 2'd0;
      change_valid_q  <= 1'b0;
      change_coin_q   <= COIN_NONE;
      busy_q          <= 1'b0;
    end else begin
      // Pulses and their data default low every cycle.
      coin_reject_q   <= 1'b0;
      sel_nack_q      <= 1'b0;
      dispense_q      <= 1'b0;
      dispense_item_q <= 2'd0;
      change_valid_q  <= 1'b0;
      change_coin_q   <= COIN_NONE;

      case (state_q)
        ST_IDLE, ST_COLLECT: begin
          if (cancel_act_s) begin
            // Cancel wins; a coin in the same cycle is refused.
            coin_reject_q <= coin_valid;
`ifdef VEND_CHANGE_RETURN_EN
            state_q <= ST_CHANGE;
            busy_q  <= 1'b1;
`else
            credit_q <= 8'd0;
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
`endif
          end else if (sel_valid) begin
            // Selection wins over a coin; the coin is refused.
            coin_reject_q <= coin_valid;
            if ((state_q == ST_COLLECT) && (credit_q >= price_s)) begin
              credit_q    <= credit_q - price_s;
              vend_item_q <= sel_item;
              state_q     <= ST_VEND;
              busy_q      <= 1'b1;
            end else begin
              sel_nack_q <= 1'b1;
            end
          end else if (coin_valid) begin
            if (coin_fits_s) begin
              credit_q <= coin_sum_s[7:0];
              state_q  <= ST_COLLECT;
            end else begin
              coin_reject_q <= 1'b1;
            end
          end else begin
            state_q <= state_q;
          end
        end

        ST_VEND: begin
          coin_reject_q   <= coin_valid;
          dispense_q      <= 1'b1;
          dispense_item_q <= vend_item_q;
`ifdef VEND_CHANGE_RETURN_EN
          if (credit_q != 8'd0) begin
            state_q <= ST_CHANGE;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
`else
          if (credit_q != 8'd0) begin
            state_q <= ST_COLLECT;
          end else begin
            state_q <= ST_IDLE;
          end
          busy_q <= 1'b0;
`endif
        end

        ST_CHANGE: begin
          coin_reject_q <= coin_valid;
`ifdef VEND_CHANGE_RETURN_EN
          if (chg_value_s == 8'd0) begin
            // Sub-5 residue cannot be paid out; drop it rather than hang.
            credit_q <= 8'd0;
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
          end else begin
            change_valid_q <= 1'b1;
            change_coin_q  <= chg_coin_s;
            credit_q       <= credit_q - chg_value_s;
            if (credit_q == chg_value_s) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_CHANGE;
              busy_q  <= 1'b1;
            end
          end
`else
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
`endif
        end

        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign credit        = credit_q;
  assign coin_reject   = coin_reject_q;
  assign sel_nack      = sel_nack_q;
  assign dispense      = dispense_q;
  assign dispense_item = dispense_item_q;
  assign change_valid  = change_valid_q;
  assign change_coin   = change_coin_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_vend_ctrl.sv
`timescale 1ns/1ps
module tb_vend_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_valid = 1'b0;
  logic [3:0] coin_code = 4'b0000;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = 2'd0;
  logic       cancel = 1'b0;
  logic [7:0] credit;
  logic       coin_reject;
  logic       sel_nack;
  logic       dispense;
  logic [1:0] dispense_item;
  logic       change_valid;
  logic [3:0] change_coin;
  logic       busy;

  vend_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .coin_valid    (coin_valid),
    .coin_code     (coin_code),
    .sel_valid     (sel_valid),
    .sel_item      (sel_item),
    .cancel        (cancel),
    .credit        (credit),
    .coin_reject   (coin_reject),
    .sel_nack      (sel_nack),
    .dispense      (dispense),
    .dispense_item (dispense_item),
    .change_valid  (change_valid),
    .change_coin   (change_coin),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int model_credit = 0;
  int prices [4] = '{15, 25, 35, 50};
  // Expected output events: {rej, nack, disp, item[1:0], chg, coin[3:0], credit[7:0]}
  logic [17:0] exp_q [$];

  function automatic logic [17:0] ev(int rej, int nack, int disp, int item,
                                     int chg, int coin, int cr);
    logic [17:0] e;
    e = {rej[0], nack[0], disp[0], item[1:0], chg[0], coin[3:0], cr[7:0]};
    return e;
  endfunction

  function automatic int coin_val(logic [3:0] code);
    case (code)
      4'b1000: return 50;
      4'b0100: return 20;
      4'b0010: return 10;
      4'b0001: return 5;
      default: return -1;
    endcase
  endfunction

  function automatic int code_of(int v);
    if (v == 50) return 8;
    else if (v == 20) return 4;
    else if (v == 10) return 2;
    else return 1;
  endfunction

  task automatic check(string name, int act, int req);
    n_checks++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Greedy payout of an amount, largest coin first.
  task automatic push_change(int amount);
    int left;
    int c;
    left = amount;
    while (left > 0) begin
      if (left >= 50) c = 50;
      else if (left >= 20) c = 20;
      else if (left >= 10) c = 10;
      else c = 5;
      left -= c;
      exp_q.push_back(ev(0, 0, 0, 0, 1, code_of(c), left));
    end
  endtask

  // Monitor: every cycle with a pulse output is one observed event.
  initial begin
    logic [17:0] act;
    logic [17:0] expv;
    forever begin
      @(negedge clk);
      if (rst && (coin_reject || sel_nack || dispense || change_valid)) begin
        act = {coin_reject, sel_nack, dispense, dispense_item, change_valid, change_coin, credit};
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL event_unexpected actual=%h required=none", act);
        end else begin
          expv = exp_q.pop_front();
          if (act !== expv) begin
            n_fail++;
            $display("FAIL event actual=%h required=%h", act, expv);
          end
        end
      end
    end
  end

  // Wait until the controller is idle and every expected event was seen.
  task automatic settle();
    int k;
    k = 0;
    do begin
      @(negedge clk);
      #1;
      k++;
    end while ((busy || exp_q.size() != 0) && k < 60);
    if (busy || exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL settle_timeout busy=%0b pending=%0d required=idle", busy, exp_q.size());
      exp_q.delete();
    end
    check("credit_idle", int'(credit), model_credit);
  endtask

  task automatic drive(bit cv, logic [3:0] cc, bit sv, logic [1:0] si, bit ca);
    coin_valid = cv;
    coin_code  = cc;
    sel_valid  = sv;
    sel_item   = si;
    cancel     = ca;
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    sel_valid  = 1'b0;
    cancel     = 1'b0;
  endtask

  task automatic op_coin(logic [3:0] code);
    int v;
    v = coin_val(code);
    if (v < 0 || model_credit + v > 255) exp_q.push_back(ev(1, 0, 0, 0, 0, 0, model_credit));
    else model_credit += v;
    drive(1'b1, code, 1'b0, 2'd0, 1'b0);
    settle();
  endtask

  task automatic op_sel(logic [1:0] item, bit with_coin, logic [3:0] code);
    int p;
    p = prices[item];
    if (model_credit >= p) begin
      model_credit -= p;
      if (with_coin) exp_q.push_back(ev(1, 0, 0, 0, 0, 0, model_credit));
      exp_q.push_back(ev(0, 0, 1, int'(item), 0, 0, model_credit));
`ifdef VEND_CHANGE_RETURN_EN
      push_change(model_credit);
      model_credit = 0;
`endif
    end else begin
      exp_q.push_back(ev(int'(with_coin), 1, 0, 0, 0, 0, model_credit));
    end
    drive(with_coin, code, 1'b1, item, 1'b0);
    settle();
  endtask

  // with_coin is only used when credit is non-zero.
  task automatic op_cancel(bit with_coin);
    if (model_credit > 0) begin
`ifdef VEND_CHANGE_RETURN_EN
      if (with_coin) exp_q.push_back(ev(1, 0, 0, 0, 0, 0, model_credit));
      push_change(model_credit);
`else
      if (with_coin) exp_q.push_back(ev(1, 0, 0, 0, 0, 0, 0));
`endif
      model_credit = 0;
    end
    drive(with_coin, 4'b0010, 1'b0, 2'd0, 1'b1);
    settle();
  endtask

  // Successful selection followed by a coin while the item is being vended.
  task automatic op_vend_then_coin(logic [1:0] item);
    model_credit -= prices[item];
    exp_q.push_back(ev(1, 0, 1, int'(item), 0, 0, model_credit));
`ifdef VEND_CHANGE_RETURN_EN
    push_change(model_credit);
    model_credit = 0;
`endif
    sel_valid = 1'b1;
    sel_item  = item;
    @(posedge clk);
    #1;
    sel_valid  = 1'b0;
    coin_valid = 1'b1;
    coin_code  = 4'b0010;
    @(posedge clk);
    #1;
    coin_valid = 1'b0;
    settle();
  endtask

  task automatic clear_credit();
    if (model_credit > 0) op_cancel(1'b0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    logic [3:0] code;
    logic [1:0] item;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_credit", int'(credit), 0);
    check("reset_pulses", int'({coin_reject, sel_nack, dispense, change_valid}), 0);
    check("reset_data", int'({dispense_item, change_coin}), 0);
    check("reset_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    // Two 20s, buy item 2 (35)
    op_coin(4'b0100);
    op_coin(4'b0100);
    check("credit_40", int'(credit), 40);
    op_sel(2'd2, 1'b0, 4'b0000);

    // Fill to 250, sixth 50 refused, then the 255 edge
    clear_credit();
    repeat (5) op_coin(4'b1000);
    check("credit_250", int'(credit), 250);
    op_coin(4'b1000);
    op_coin(4'b0001);
    op_coin(4'b0001);
    clear_credit();

    // Insufficient credit and illegal coin code
    op_coin(4'b0010);
    op_sel(2'd1, 1'b0, 4'b0000);
    op_coin(4'b0011);
    op_coin(4'b0000);
    clear_credit();
    op_sel(2'd0, 1'b0, 4'b0000);

    // 50,20,10 then cancel
    op_coin(4'b1000);
    op_coin(4'b0100);
    op_coin(4'b0010);
    op_cancel(1'b0);

    // Coin and selection together at credit 25
    op_coin(4'b0100);
    op_coin(4'b0001);
    op_sel(2'd1, 1'b1, 4'b0100);
    clear_credit();

    // Coin during vend, cancel with coin
    op_coin(4'b1000);
    op_coin(4'b1000);
    op_vend_then_coin(2'd0);
    op_coin(4'b0100);
    op_cancel(1'b1);

    // Reset while the transaction is in flight
    clear_credit();
`ifdef VEND_CHANGE_RETURN_EN
    op_coin(4'b1000);
    op_coin(4'b0100);
    op_coin(4'b0010);
    cancel = 1'b1;
    @(posedge clk);
    #1;
    cancel = 1'b0;
    @(posedge clk);
    #2;
`else
    op_coin(4'b0100);
    op_coin(4'b0100);
    sel_valid = 1'b1;
    sel_item  = 2'd1;
    @(posedge clk);
    #1;
    sel_valid = 1'b0;
`endif
    rst = 1'b0;
    #1;
    check("rst_async_credit", int'(credit), 0);
    check("rst_async_pulses", int'({coin_reject, sel_nack, dispense, change_valid}), 0);
    check("rst_async_data", int'({dispense_item, change_coin}), 0);
    check("rst_async_busy", int'(busy), 0);
    exp_q.delete();
    model_credit = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    settle();

    // Randomized traffic
    for (int i = 0; i < 300; i++) begin
      r    = $urandom_range(0, 99);
      code = 4'b0001 << $urandom_range(0, 3);
      item = 2'($urandom_range(0, 3));
      if (r < 45) op_coin(code);
      else if (r < 52) op_coin(4'($urandom_range(0, 15)));
      else if (r < 70) op_sel(item, 1'b0, 4'b0000);
      else if (r < 80) op_sel(item, 1'b1, code);
      else if (r < 87) op_cancel((model_credit > 0) ? 1'($urandom_range(0, 1)) : 1'b0);
      else if (r < 93 && model_credit >= prices[item]) op_vend_then_coin(item);
      else op_coin(4'b1000);
    end

    repeat (5) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
